axi4_lite_reg_bank: RTL and testbench
=====================================

Name: axi4_lite_reg_bank

Overview:
- 32-bit AXI4-Lite slave register bank that sits directly downstream of the 64-to-32 data-width translator and consumes its narrowed AW/W/B/AR/R channels.
- Holds NREG software-visible 32-bit control registers, each with a per-register write pulse.
- Drives the control registers out to fabric logic.
- Handles AW and W arriving in any order, one outstanding write and one outstanding read.

Parameters:
- AW, 32, address width of the AXI4-Lite interface.
- NREG, 16, number of 32-bit registers (1..256).
- RESET_VAL, 32'h0000_0000, reset value loaded into every register.

Ports:
- aclk  input  1  bus clock; all logic on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s  interface  axi4_lite_if.s  AXI4-Lite slave port: AW-bit address, 32-bit data, 4-bit wstrb.
- regs_o  output  NREG*32  register contents; register i is at [32*i+31:32*i].
- wr_pulse_o  output  NREG  one-cycle pulse on bit i when register i is updated.

Behaviour:
- Reset (aresetn low, asynchronous):
  - awready, wready, bvalid, arready, rvalid = 0; rdata = 0; bresp/rresp = 2'b00.
  - All registers = RESET_VAL; wr_pulse_o = 0.
  - Holding flags cleared.
  - First ready assertion occurs one cycle after reset release.
- Decode:
  - Word index = addr[AW-1:2]; addr[1:0] ignored.
  - Index >= NREG means out of range.
- Write channel, states W_IDLE / W_RESP:
  - In W_IDLE, awready = !aw_held and wready = !w_held, so each channel accepts independently.
  - On an AW handshake: latch awaddr and set aw_held. On a W handshake: latch wdata/wstrb and set w_held. Both may handshake in the same cycle.
  - When aw_held && w_held, on the next edge:
    - byte-merge wdata into the register using wstrb;
    - pulse wr_pulse_o[i];
    - set bvalid = 1, bresp = OKAY;
    - clear both held flags;
    - enter W_RESP.
  - Latency: bvalid rises 1 cycle after the later of the AW/W handshakes.
  - In W_RESP, awready = wready = 0. bvalid and bresp stay stable until bready; on the handshake, bvalid drops and the FSM returns to W_IDLE. A back-to-back write needs at least 1 idle cycle.
  - wstrb = 4'h0: register unchanged, but wr_pulse_o still fires and the response is OKAY.
- Read channel, states R_IDLE / R_DATA:
  - arready = !rvalid.
  - On an AR handshake: rdata is registered from the decoded register, rvalid = 1 next edge, and the FSM enters R_DATA.
  - rdata and rresp are held stable until rready; on the handshake, rvalid drops and the FSM returns to R_IDLE.
  - Throughput: one read per 2 cycles.
- Simultaneous read/write:
  - The read and write FSMs are independent.
  - If a read handshake and a register update happen on the same edge for the same index, rdata returns the pre-update value.
- Out-of-range write: no register changes, no wr_pulse_o, bresp per the optional feature.
- Out-of-range read: rdata = 0, rresp per the optional feature.
- Reset mid-transaction: all held flags and valids clear immediately. No partial write is ever committed.

Optional Feature:
- Macro: AXI_REG_BANK_SLVERR_EN.
- Defined: out-of-range accesses return bresp/rresp = SLVERR (2'b10).
- Undefined: out-of-range accesses return OKAY; writes are silently dropped and reads return 0.
- In-range behaviour is identical in both builds.

Test Plan:
- Reset release, then read index 3 -> rvalid 1 cycle after the AR handshake, rdata = RESET_VAL, rresp = OKAY.
- AW (addr 0x08) and W (0xDEADBEEF, wstrb F) in the same cycle -> bvalid next cycle, wr_pulse_o[2] for 1 cycle, regs_o[95:64] = 0xDEADBEEF; readback matches.
- W at cycle 0, AW at cycle 3 (addr 0x04, data 0x11223344, wstrb 4'b0101), with register 1 previously 0xAABBCCDD -> awready stays high while wready is low; register 1 = 0xAA22CC44; bvalid at cycle 4.
- bready held low for 5 cycles -> bvalid and bresp stable; awready/wready stay 0; a new AW is not accepted until the cycle after the B handshake.
- Write and read to index NREG (addr 0x40 with NREG=16) -> no wr_pulse_o, rdata = 0; resp = 2'b10 with the macro defined, 2'b00 without it.
- Assert aresetn low between the AW and W handshakes -> after release, the target register still holds RESET_VAL and bvalid never asserts.

Source files
------------

// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite bus bundle (AW-bit address, 32-bit data) shared by the register bank and its master.
// Modport m is the bus master side, modport s is the slave side.
interface axi4_lite_if #(
    parameter int AW = 32
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave bank of NREG 32-bit control registers with per-register write pulses.
// Define AXI_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_reg_bank #(
    parameter int          AW        = 32,
    parameter int          NREG      = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic               aclk,
    input  logic               aresetn,
    axi4_lite_if.s             s,
    output logic [NREG*32-1:0] regs_o,
    output logic [NREG-1:0]    wr_pulse_o
);

    localparam int             IW          = AW - 2;
    localparam logic [IW-1:0]  NREG_IDX    = IW'(NREG);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
`ifdef AXI_REG_BANK_SLVERR_EN
    localparam logic [1:0]     RESP_OOR    = 2'b10;
`else
    localparam logic [1:0]     RESP_OOR    = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e        w_state_q, w_state_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic [IW-1:0]   aw_idx_q, aw_idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [NREG-1:0] wr_pulse_q, wr_pulse_d;
    logic [31:0]     regs_q [NREG];
    logic [31:0]     regs_d [NREG];

    r_state_e        r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;

    logic            aw_in_range;
    logic [IW-1:0]   ar_idx;
    logic            ar_in_range;
    logic [31:0]     rd_val;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{s.awaddr[1:0], s.araddr[1:0]};

    assign aw_in_range = (aw_idx_q < NREG_IDX);
    assign ar_idx      = s.araddr[AW-1:2];
    assign ar_in_range = (ar_idx < NREG_IDX);

    // Write path: AW and W are captured independently; the commit happens one edge after both are held.
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    if (aw_in_range) begin
                        for (int i = 0; i < NREG; i++) begin
                            if (aw_idx_q == IW'(i)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (wstrb_q[b]) begin
                                        regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                                    end
                                end
                                wr_pulse_d[i] = 1'b1;
                            end
                        end
                    end
                    bvalid_d  = 1'b1;
                    bresp_d   = aw_in_range ? RESP_OKAY : RESP_OOR;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (s.awvalid && awready_q) begin
                        aw_idx_d  = s.awaddr[AW-1:2];
                        aw_held_d = 1'b1;
                    end
                    if (s.wvalid && wready_q) begin
                        wdata_d  = s.wdata;
                        wstrb_d  = s.wstrb;
                        w_held_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads sample regs_q, so a read landing on the same edge as a commit returns the old value.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ar_idx == IW'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (s.arvalid && arready_q) begin
                    rdata_d   = rd_val;
                    rresp_d   = ar_in_range ? RESP_OKAY : RESP_OOR;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = !rvalid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Self-checking bench for axi4_lite_reg_bank: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_axi4_lite_reg_bank;

    localparam int          NREG      = 16;
    localparam logic [31:0] RESET_VAL = 32'hA5A5_0F0F;
`ifdef AXI_REG_BANK_SLVERR_EN
    localparam logic [1:0]  OOR_EXP   = 2'b10;
`else
    localparam logic [1:0]  OOR_EXP   = 2'b00;
`endif

    logic               aclk;
    logic               aresetn;
    logic [NREG*32-1:0] regs_o;
    logic [NREG-1:0]    wr_pulse_o;

    int                 errors;
    int                 checks;
    logic [31:0]        model_regs [NREG];
    logic [NREG-1:0]    pulse_seen;

    axi4_lite_if #(.AW(32)) bus ();

    axi4_lite_reg_bank #(
        .AW        (32),
        .NREG      (NREG),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s          (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Sticky record of every write pulse seen; tests clear it before a transaction.
    always @(negedge aclk) begin
        pulse_seen = pulse_seen | wr_pulse_o;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic logic [NREG*32-1:0] model_vec();
        logic [NREG*32-1:0] v;
        for (int i = 0; i < NREG; i++) v[32*i +: 32] = model_regs[i];
        return v;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic to);
        logic aw_fire, w_fire, b_fire, done;
        done        = 1'b0;
        resp        = 2'b11;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            b_fire  = bus.bvalid && bus.bready;
            if (b_fire) resp = bus.bresp;
            @(posedge aclk); #1;
            if (aw_fire) bus.awvalid = 1'b0;
            if (w_fire)  bus.wvalid  = 1'b0;
            if (b_fire) begin
                bus.bready = 1'b0;
                done       = 1'b1;
            end
        end
        to = !done;
        if (!done) begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            bus.bready  = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic to);
        logic ar_fire, r_fire, done;
        done        = 1'b0;
        data        = 32'hxxxx_xxxx;
        resp        = 2'b11;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            ar_fire = bus.arvalid && bus.arready;
            r_fire  = bus.rvalid && bus.rready;
            if (r_fire) begin
                data = bus.rdata;
                resp = bus.rresp;
            end
            @(posedge aclk); #1;
            if (ar_fire) bus.arvalid = 1'b0;
            if (r_fire) begin
                bus.rready = 1'b0;
                done       = 1'b1;
            end
        end
        to = !done;
        if (!done) begin
            bus.arvalid = 1'b0;
            bus.rready  = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        for (int i = 0; i < NREG; i++) model_regs[i] = RESET_VAL;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (bus.awready !== 1'b0) begin errors++; $display("[TB] FAIL reset_awready: got %b expected 0", bus.awready); end
        checks++; if (bus.wready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wready: got %b expected 0", bus.wready); end
        checks++; if (bus.arready !== 1'b0) begin errors++; $display("[TB] FAIL reset_arready: got %b expected 0", bus.arready); end
        checks++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valids: got b=%b r=%b expected 0 0", bus.bvalid, bus.rvalid); end
        checks++; if (bus.rdata !== 32'h0 || bus.rresp !== 2'b00 || bus.bresp !== 2'b00) begin errors++; $display("[TB] FAIL reset_data: got rdata=%h rresp=%b bresp=%b expected 0", bus.rdata, bus.rresp, bus.bresp); end
        checks++; if (wr_pulse_o !== '0) begin errors++; $display("[TB] FAIL reset_pulse: got %h expected 0", wr_pulse_o); end
        checks++; if (regs_o !== model_vec()) begin errors++; $display("[TB] FAIL reset_regs: got %h expected %h", regs_o[31:0], RESET_VAL); end
        aresetn = 1'b1;
        #1;
        checks++; if (bus.awready !== 1'b0) begin errors++; $display("[TB] FAIL ready_delay: got awready=%b expected 0", bus.awready); end
        @(posedge aclk); #1;
        checks++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1 || bus.arready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: got aw=%b w=%b ar=%b expected 1 1 1", bus.awready, bus.wready, bus.arready); end
        bus.araddr  = 32'h0000_000C;
        bus.arvalid = 1'b1;
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL read3_rvalid: got %b expected 1", bus.rvalid); end
        checks++; if (bus.rdata !== RESET_VAL || bus.rresp !== 2'b00) begin errors++; $display("[TB] FAIL read3_data: got %h/%b expected %h/00", bus.rdata, bus.rresp, RESET_VAL); end
        checks++; if (bus.arready !== 1'b0) begin errors++; $display("[TB] FAIL read3_arready: got %b expected 0", bus.arready); end
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
        checks++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin errors++; $display("[TB] FAIL read3_done: got rvalid=%b arready=%b expected 0 1", bus.rvalid, bus.arready); end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] rd; logic [1:0] rr; logic to;
        bus.awaddr = 32'h0000_0008; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin errors++; $display("[TB] FAIL sc_held: got bvalid=%b aw=%b w=%b expected 0 0 0", bus.bvalid, bus.awready, bus.wready); end
        @(posedge aclk); #1;
        model_regs[2] = 32'hDEAD_BEEF;
        checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin errors++; $display("[TB] FAIL sc_bvalid: got %b/%b expected 1/00", bus.bvalid, bus.bresp); end
        checks++; if (wr_pulse_o !== 16'h0004) begin errors++; $display("[TB] FAIL sc_pulse: got %h expected 0004", wr_pulse_o); end
        checks++; if (regs_o[95:64] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sc_reg2: got %h expected deadbeef", regs_o[95:64]); end
        @(posedge aclk); #1;
        checks++; if (wr_pulse_o !== '0 || bus.bvalid !== 1'b1) begin errors++; $display("[TB] FAIL sc_pulse_width: got pulse=%h bvalid=%b expected 0 1", wr_pulse_o, bus.bvalid); end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("[TB] FAIL sc_bdone: got %b expected 0", bus.bvalid); end
        axi_read(32'h0000_0008, rd, rr, to);
        checks++; if (to || rd !== model_regs[2] || rr !== 2'b00) begin errors++; $display("[TB] FAIL sc_readback: got %h/%b to=%b expected %h/00", rd, rr, to, model_regs[2]); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] br; logic to;
        axi_write(32'h0000_0004, 32'hAABB_CCDD, 4'hF, br, to);
        model_regs[1] = 32'hAABB_CCDD;
        checks++; if (to || br !== 2'b00) begin errors++; $display("[TB] FAIL wa_setup: got bresp=%b to=%b expected 00 0", br, to); end
        bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wa_wait%0d: got aw=%b w=%b b=%b expected 1 0 0", c, bus.awready, bus.wready, bus.bvalid); end
            if (c < 2) begin
                @(posedge aclk); #1;
            end
        end
        bus.awaddr = 32'h0000_0004; bus.awvalid = 1'b1;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("[TB] FAIL wa_early_b: got %b expected 0", bus.bvalid); end
        @(posedge aclk); #1;
        model_regs[1] = merge(model_regs[1], 32'h1122_3344, 4'b0101);
        checks++; if (bus.bvalid !== 1'b1 || wr_pulse_o !== 16'h0002) begin errors++; $display("[TB] FAIL wa_commit: got bvalid=%b pulse=%h expected 1 0002", bus.bvalid, wr_pulse_o); end
        checks++; if (regs_o[63:32] !== model_regs[1]) begin errors++; $display("[TB] FAIL wa_reg1: got %h expected %h", regs_o[63:32], model_regs[1]); end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic test_bready_stall();
        logic [31:0] d; logic [1:0] br; logic to;
        d = $urandom;
        bus.awaddr = 32'h0000_0010; bus.wdata = d; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(posedge aclk); #1;
        model_regs[4] = d;
        bus.awaddr = 32'h0000_0014; bus.awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d: got b=%b resp=%b aw=%b w=%b expected 1 00 0 0", c, bus.bvalid, bus.bresp, bus.awready, bus.wready); end
            @(posedge aclk); #1;
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0; bus.awvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got bvalid=%b awready=%b expected 0 1", bus.bvalid, bus.awready); end
        checks++; if (regs_o[159:128] !== model_regs[4]) begin errors++; $display("[TB] FAIL stall_reg4: got %h expected %h", regs_o[159:128], model_regs[4]); end
        d = $urandom;
        axi_write(32'h0000_0014, d, 4'hF, br, to);
        model_regs[5] = d;
        checks++; if (to || br !== 2'b00 || regs_o !== model_vec()) begin errors++; $display("[TB] FAIL stall_next: got bresp=%b to=%b reg5=%h expected 00 0 %h", br, to, regs_o[191:160], d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic [1:0] r; logic to;
        pulse_seen = '0;
        axi_write(32'h0000_0040, $urandom, 4'hF, r, to);
        checks++; if (to || r !== OOR_EXP) begin errors++; $display("[TB] FAIL oor_bresp: got %b to=%b expected %b", r, to, OOR_EXP); end
        checks++; if (pulse_seen !== '0) begin errors++; $display("[TB] FAIL oor_pulse: got %h expected 0", pulse_seen); end
        checks++; if (regs_o !== model_vec()) begin errors++; $display("[TB] FAIL oor_regs: got reg0=%h expected %h", regs_o[31:0], model_regs[0]); end
        axi_read(32'h0000_0040, rd, r, to);
        checks++; if (to || rd !== 32'h0 || r !== OOR_EXP) begin errors++; $display("[TB] FAIL oor_read: got %h/%b to=%b expected 0/%b", rd, r, to, OOR_EXP); end
        axi_read(32'hFFFF_FFFC, rd, r, to);
        checks++; if (to || rd !== 32'h0 || r !== OOR_EXP) begin errors++; $display("[TB] FAIL oor_read_top: got %h/%b to=%b expected 0/%b", rd, r, to, OOR_EXP); end
    endtask

    task automatic test_read_during_write();
        logic [1:0] br; logic to;
        axi_write(32'h0000_0018, 32'h0102_0304, 4'hF, br, to);
        model_regs[6] = 32'h0102_0304;
        bus.awaddr = 32'h0000_0018; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0; bus.rready = 1'b0;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h0000_0018; bus.arvalid = 1'b1;
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== model_regs[6]) begin errors++; $display("[TB] FAIL rdw_old: got rvalid=%b rdata=%h expected 1 %h", bus.rvalid, bus.rdata, model_regs[6]); end
        model_regs[6] = 32'hCAFE_F00D;
        checks++; if (bus.bvalid !== 1'b1 || regs_o[223:192] !== model_regs[6]) begin errors++; $display("[TB] FAIL rdw_new: got bvalid=%b reg6=%h expected 1 %h", bus.bvalid, regs_o[223:192], model_regs[6]); end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        checks++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rdw_done: got b=%b r=%b expected 0 0", bus.bvalid, bus.rvalid); end
    endtask

    task automatic test_random();
        logic [31:0] d, rd; logic [3:0] st; logic [1:0] r; logic to;
        int idx; logic inr; logic [NREG-1:0] exp_pulse;
        pulse_seen = '0;
        axi_write(32'h0000_001C, 32'hFFFF_FFFF, 4'h0, r, to);
        checks++; if (to || r !== 2'b00 || pulse_seen !== 16'h0080 || regs_o !== model_vec()) begin errors++; $display("[TB] FAIL zero_strb: got resp=%b pulse=%h reg7=%h expected 00 0080 %h", r, pulse_seen, regs_o[255:224], model_regs[7]); end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, NREG + 3);
            inr = (idx < NREG);
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom;
                st = 4'($urandom_range(0, 15));
                pulse_seen = '0;
                axi_write(32'(idx * 4 + $urandom_range(0, 3)), d, st, r, to);
                exp_pulse = '0;
                if (inr) begin
                    model_regs[idx] = merge(model_regs[idx], d, st);
                    exp_pulse[idx]  = 1'b1;
                end
                checks++; if (to || r !== (inr ? 2'b00 : OOR_EXP) || pulse_seen !== exp_pulse || regs_o !== model_vec()) begin errors++; $display("[TB] FAIL rnd_write%0d idx=%0d: got resp=%b to=%b pulse=%h expected resp=%b pulse=%h", n, idx, r, to, pulse_seen, inr ? 2'b00 : OOR_EXP, exp_pulse); end
            end else begin
                axi_read(32'(idx * 4 + $urandom_range(0, 3)), rd, r, to);
                checks++; if (to || rd !== (inr ? model_regs[idx] : 32'h0) || r !== (inr ? 2'b00 : OOR_EXP)) begin errors++; $display("[TB] FAIL rnd_read%0d idx=%0d: got %h/%b to=%b expected %h/%b", n, idx, rd, r, to, inr ? model_regs[idx] : 32'h0, inr ? 2'b00 : OOR_EXP); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        bus.awaddr = 32'h0000_0014; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        checks++; if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin errors++; $display("[TB] FAIL mid_aw_held: got aw=%b w=%b expected 0 1", bus.awready, bus.wready); end
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model_regs[i] = RESET_VAL;
        checks++; if (bus.bvalid !== 1'b0 || bus.wready !== 1'b0 || regs_o !== model_vec()) begin errors++; $display("[TB] FAIL mid_async: got bvalid=%b wready=%b reg5=%h expected 0 0 %h", bus.bvalid, bus.wready, regs_o[191:160], RESET_VAL); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        pulse_seen = '0;
        bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk); #1;
            bus.wvalid = 1'b0;
            if (bus.bvalid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("[TB] FAIL mid_no_bvalid: got bvalid asserted expected never"); end
        checks++; if (regs_o[191:160] !== RESET_VAL || pulse_seen !== '0) begin errors++; $display("[TB] FAIL mid_reg5: got %h pulse=%h expected %h 0", regs_o[191:160], pulse_seen, RESET_VAL); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        pulse_seen = '0;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_bready_stall();
        test_out_of_range();
        test_read_during_write();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
